// File: rtl/sn_host_pkg.sv
// sn_host_pkg: shared types and widths for the UART register-protocol host master.
package sn_host_pkg;
    localparam int SN_PROT_ADDR_BW = 7;
    localparam int SN_PROT_DATA_BW = 8;
    typedef enum logic [2:0] {IDLE, TX_HDR, TX_DAT, RX_WAIT, RX_BYTE, DONE} sn_host_state_e;
    typedef struct packed {
        logic                       r0w1;
        logic [SN_PROT_ADDR_BW-1:0] addr;
        logic [SN_PROT_DATA_BW-1:0] wdata;
    } sn_host_cmd_t;
endpackage

// File: rtl/sn_uart_byte_tx.sv
// sn_uart_byte_tx: serialises one byte as start, 8 data bits LSB first, then stop bits.
// done is high during the final cycle of the frame so a new load can follow with no gap.
module sn_uart_byte_tx #(
    parameter int P_CLKS_PER_BIT = 10,
    parameter int P_BITS_PER_PKT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       done,
    output logic       uart_tx
);
    localparam int CW = $clog2(P_CLKS_PER_BIT + 1);
    localparam int BW = $clog2(P_BITS_PER_PKT + 1);
    localparam logic [CW-1:0] CLK_LAST = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(P_BITS_PER_PKT - 1);
    logic [P_BITS_PER_PKT-1:0] frame, sh_q, sh_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic active_q, active_d, tx_q, tx_d, bit_end;
    assign frame   = {{(P_BITS_PER_PKT - 9){1'b1}}, byte_in, 1'b0};
    assign bit_end = active_q && ccnt_q == CLK_LAST;
    assign done    = bit_end && bcnt_q == BIT_LAST;
    assign uart_tx = tx_q;
    always_comb begin
        active_d = load || (active_q && !done);
        ccnt_d   = (load || bit_end || !active_q) ? '0 : ccnt_q + CW'(1);
        bcnt_d   = load ? '0 : bit_end ? bcnt_q + BW'(1) : bcnt_q;
        sh_d     = load ? {1'b1, frame[P_BITS_PER_PKT-1:1]} : bit_end ? {1'b1, sh_q[P_BITS_PER_PKT-1:1]} : sh_q;
        tx_d     = load ? 1'b0 : bit_end ? sh_q[0] : tx_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            ccnt_q   <= '0;
            bcnt_q   <= '0;
            sh_q     <= '1;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            ccnt_q   <= ccnt_d;
            bcnt_q   <= bcnt_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: rtl/sn_uart_host_master.sv
// sn_uart_host_master: host-side initiator of the UART register protocol (write: header+data, read: header then 1-byte reply).
// Define SN_HOST_CMD_FIFO_EN to place a command FIFO between the cmd port and the FSM.
module sn_uart_host_master
    import sn_host_pkg::*;
#(
    parameter int P_CLKS_PER_BIT = 10,
    parameter int P_BITS_PER_PKT = 10,
    parameter int P_RESP_TIMEOUT = 200,
    parameter int P_FIFO_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_r0w1,
    input  logic [SN_PROT_ADDR_BW-1:0] cmd_addr,
    input  logic [SN_PROT_DATA_BW-1:0] cmd_wdata,
    output logic                       rsp_valid,
    output logic [SN_PROT_DATA_BW-1:0] rsp_rdata,
    output logic                       rsp_err,
    output logic                       uart_tx,
    input  logic                       uart_rx,
    output logic                       busy
);
    localparam int CW = $clog2(P_CLKS_PER_BIT + 1);
    localparam int TW = $clog2(P_RESP_TIMEOUT + 1);
    localparam logic [CW-1:0] CLK_MID  = CW'(P_CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CLK_LAST = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(P_RESP_TIMEOUT - 1);
    sn_host_state_e state_q, state_d;
    sn_host_cmd_t cmd_q, cmd_d, src;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [3:0] rbit_q, rbit_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0] rsh_q, rsh_d, rsp_rdata_q, rsp_rdata_d, tx_byte;
    logic [2:0] rx_q;
    logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, ready_q, ready_d;
    logic rx_sync, fall, avail, take, finish, load, tx_done;
    assign rx_sync = rx_q[1];
    assign fall    = rx_q[2] & ~rx_q[1];
    assign finish  = (state_q == TX_DAT && tx_done) ||
                     (state_q == RX_WAIT && !fall && tcnt_q == TO_LAST) ||
                     (state_q == RX_BYTE && rcnt_q == CLK_MID && rbit_q == 4'd9);
    assign take    = avail && (state_q == IDLE || finish);
    assign load    = take || (state_q == TX_HDR && tx_done && cmd_q.r0w1);
    assign tx_byte = take ? {src.r0w1, src.addr} : cmd_q.wdata;
`ifdef SN_HOST_CMD_FIFO_EN
    // The head entry stays queued while it executes, so it counts towards full.
    localparam int AW = $clog2(P_FIFO_DEPTH);
    sn_host_cmd_t mem_q [P_FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0] cnt_q, cnt_d;
    logic push;
    assign push    = cmd_valid & ready_q;
    assign avail   = (state_q == IDLE) ? cnt_q != '0 : cnt_q > (AW + 1)'(1);
    assign src     = mem_q[(state_q == IDLE) ? rd_q : rd_q + AW'(1)];
    assign cnt_d   = cnt_q + (AW + 1)'(push) - (AW + 1)'(finish);
    assign ready_d = cnt_d != (AW + 1)'(P_FIFO_DEPTH);
    assign busy    = state_q != IDLE || cnt_q != '0;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd_r0w1, cmd_addr, cmd_wdata};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= finish ? rd_q + AW'(1) : rd_q;
            wr_q  <= push ? wr_q + AW'(1) : wr_q;
            cnt_q <= cnt_d;
        end
    end
`else
    assign avail   = state_q == IDLE && cmd_valid && ready_q;
    assign src     = {cmd_r0w1, cmd_addr, cmd_wdata};
    assign ready_d = state_d == IDLE;
    assign busy    = state_q != IDLE;
`endif
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rcnt_d  = rcnt_q;
        rbit_d  = rbit_q;
        tcnt_d  = tcnt_q;
        rsh_d   = rsh_q;
        case (state_q)
            TX_HDR: begin
                state_d = tx_done ? (cmd_q.r0w1 ? TX_DAT : RX_WAIT) : TX_HDR;
                tcnt_d  = '0;
            end
            RX_WAIT: begin
                state_d = fall ? RX_BYTE : RX_WAIT;
                rcnt_d  = '0;
                rbit_d  = '0;
                tcnt_d  = fall ? tcnt_q : tcnt_q + TW'(1);
            end
            RX_BYTE: begin
                rcnt_d  = (rcnt_q == CLK_LAST) ? '0 : rcnt_q + CW'(1);
                rbit_d  = (rcnt_q == CLK_LAST) ? rbit_q + 4'd1 : rbit_q;
                // A start bit that is high again at mid-bit was only a glitch.
                state_d = (rcnt_q == CLK_MID && rbit_q == 4'd0 && rx_sync) ? RX_WAIT : RX_BYTE;
                rsh_d   = (rcnt_q == CLK_MID && rbit_q != 4'd0) ? {rx_sync, rsh_q[7:1]} : rsh_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase
        state_d     = take ? TX_HDR : finish ? DONE : state_d;
        cmd_d       = take ? src : cmd_d;
        rsp_valid_d = finish;
        rsp_err_d   = finish ? (state_q == RX_WAIT || (state_q == RX_BYTE && !rx_sync)) : rsp_err_q;
        rsp_rdata_d = finish ? ((state_q == RX_BYTE && rx_sync) ? rsh_q : 8'h00) : rsp_rdata_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rcnt_q      <= '0;
            rbit_q      <= '0;
            tcnt_q      <= '0;
            rsh_q       <= '0;
            rx_q        <= '1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rcnt_q      <= rcnt_d;
            rbit_q      <= rbit_d;
            tcnt_q      <= tcnt_d;
            rsh_q       <= rsh_d;
            rx_q        <= {rx_q[1:0], uart_rx};
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    sn_uart_byte_tx #(
        .P_CLKS_PER_BIT(P_CLKS_PER_BIT),
        .P_BITS_PER_PKT(P_BITS_PER_PKT)
    ) u_tx (
        .clk(clk),
        .rst(rst),
        .load(load),
        .byte_in(tx_byte),
        .done(tx_done),
        .uart_tx(uart_tx)
    );
endmodule

// File: tb/tb_sn_uart_host_master.sv
// tb_sn_uart_host_master: directed, table-driven bench for sn_uart_host_master (default parameters).
module tb_sn_uart_host_master;
    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_r0w1 = 1'b0, uart_rx = 1'b1;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic cmd_ready, rsp_valid, rsp_err, uart_tx, busy;
    logic [7:0] rsp_rdata;
    int n_chk = 0, n_fail = 0;
`ifdef SN_HOST_CMD_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    always #5 clk = ~clk;
    sn_uart_host_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_r0w1(cmd_r0w1), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .busy(busy)
    );
    typedef struct {
        logic       r0w1;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       reply_on;
        logic       stop;
        logic [7:0] reply;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_j;
    } vec_t;
    vec_t vecs[7];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic handshake(input logic r0w1, input logic [6:0] addr, input logic [7:0] wdata, input string tag);
        cmd_valid = 1'b1;
        cmd_r0w1  = r0w1;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        for (int w = 0; w < 1000 && !cmd_ready; w++) tick();
        check({tag, "_ready"}, 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        cmd_r0w1  = ~r0w1;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        check({tag, "_busy"}, 32'(busy), 1);
`ifndef SN_HOST_CMD_FIFO_EN
        check({tag, "_ready_low"}, 32'(cmd_ready), 0);
`endif
        repeat (LAT) tick();
    endtask
    task automatic run_cmd(input vec_t v, input string tag);
        logic [19:0] stream, cap;
        logic [9:0] rf;
        logic [7:0] rdata_s;
        logic err_s;
        int nbits, bad, first, pulses;
        stream = {frame(v.wdata), frame({v.r0w1, v.addr})};
        nbits  = v.r0w1 ? 20 : 10;
        rf     = {v.stop, v.reply, 1'b0};
        bad = 0; cap = '0; first = -1; pulses = 0; rdata_s = 8'hEE; err_s = 1'bx;
        handshake(v.r0w1, v.addr, v.wdata, tag);
        for (int k = 0; k < nbits * 10; k++) begin
            if (uart_tx !== stream[k / 10] || rsp_valid !== 1'b0) bad++;
            if (k % 10 == 5) cap[k / 10] = uart_tx;
            tick();
        end
        check({tag, "_hdr"}, 32'(cap[9:0]), 32'(stream[9:0]));
        if (v.r0w1) check({tag, "_dat"}, 32'(cap[19:10]), 32'(stream[19:10]));
        for (int j = 0; j < 230; j++) begin
            if (rsp_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first   = j;
                    rdata_s = rsp_rdata;
                    err_s   = rsp_err;
                end
            end
            if (uart_tx !== 1'b1) bad++;
            uart_rx = (v.reply_on && j >= 15 && j < 115) ? rf[(j - 15) / 10] : 1'b1;
            tick();
        end
        check({tag, "_tx_bad_cycles"}, 32'(bad), 0);
        check({tag, "_rsp_cycle"}, 32'(first), 32'(v.exp_j));
        check({tag, "_rsp_pulses"}, 32'(pulses), 1);
        check({tag, "_rdata"}, 32'(rdata_s), 32'(v.exp_rdata));
        check({tag, "_err"}, 32'(err_s), 32'(v.exp_err));
        check({tag, "_idle_busy"}, 32'(busy), 0);
    endtask
    task automatic reset_mid_frame();
        int pulses, bad;
        pulses = 0; bad = 0;
        handshake(1'b1, 7'h05, 8'hA3, "rstmid");
        repeat (43) tick();
        check("rstmid_tx_before", 32'(uart_tx), 0);
        rst = 1'b1;
        #1;
        check("rstmid_tx_async", 32'(uart_tx), 1);
        check("rstmid_ready_in_rst", 32'(cmd_ready), 0);
        check("rstmid_busy_in_rst", 32'(busy), 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rstmid_ready_at_release", 32'(cmd_ready), 0);
        tick();
        check("rstmid_ready_next", 32'(cmd_ready), 1);
        for (int j = 0; j < 250; j++) begin
            if (rsp_valid === 1'b1) pulses++;
            if (uart_tx !== 1'b1) bad++;
            tick();
        end
        check("rstmid_no_rsp", 32'(pulses), 0);
        check("rstmid_tx_idle", 32'(bad), 0);
    endtask
`ifdef SN_HOST_CMD_FIFO_EN
    function automatic logic fifo_bit(input int k);
        logic [9:0] fr;
        fr = ((k % 200) >= 100) ? frame(8'((k / 200) * 37 + 5)) : frame({1'b1, 7'((k / 200) * 9 + 1)});
        return (k >= 800) ? 1'b1 : fr[(k % 100) / 10];
    endfunction
    task automatic fifo_test();
        int bad, pulses;
        bad = 0; pulses = 0;
        for (int i = 0; i < 4; i++) begin
            check("fifo_push_ready", 32'(cmd_ready), 1);
            cmd_valid = 1'b1;
            cmd_r0w1  = 1'b1;
            cmd_addr  = 7'(i * 9 + 1);
            cmd_wdata = 8'(i * 37 + 5);
            tick();
        end
        check("fifo_full_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b0;
        for (int k = 2; k < 830; k++) begin
            if (uart_tx !== fifo_bit(k)) bad++;
            if (rsp_valid === 1'b1) begin
                pulses++;
                if (k % 200 != 0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) bad++;
            end
            tick();
        end
        check("fifo_stream_bad", 32'(bad), 0);
        check("fifo_rsp_pulses", 32'(pulses), 4);
        check("fifo_idle_busy", 32'(busy), 0);
    endtask
`endif
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0] = '{1'b1, 7'h05, 8'hA3, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 0};
        vecs[1] = '{1'b0, 7'h12, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0, 114};
        vecs[2] = '{1'b0, 7'h40, 8'h99, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 200};
        vecs[3] = '{1'b0, 7'h33, 8'h00, 1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 114};
        vecs[4] = '{1'b1, 7'h7F, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 0};
        vecs[5] = '{1'b0, 7'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 114};
        vecs[6] = '{1'b1, 7'h2A, 8'h5C, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 0};
        tick();
        check("rst_uart_tx", 32'(uart_tx), 1);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        #1;
        check("release_ready_same", 32'(cmd_ready), 0);
        tick();
        check("release_ready_next", 32'(cmd_ready), 1);
        for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));
        reset_mid_frame();
        run_cmd(vecs[6], "post_rst");
`ifdef SN_HOST_CMD_FIFO_EN
        fifo_test();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
